// File: rtl/xm23_run_control.sv
// xm23_run_control: divided CPU clock, run/pause/single-step/halt sequencing,
// boot-address forcing and a saturating CPU cycle counter for the XM23 board.
module xm23_run_control #(
    parameter int unsigned DIV_W        = 32,
    parameter int unsigned DIV0         = 25000000,
    parameter int unsigned DIV1         = 2500000,
    parameter int unsigned DIV2         = 250000,
    parameter int unsigned DIV3         = 3,
    parameter int unsigned CNT_W        = 64,
    parameter logic [15:0] HALT_INST    = 16'h3FFF,
    parameter int unsigned HALT_CONFIRM = 2
) (
    input  logic             clk_in,
    input  logic             init_n,
    input  logic [1:0]       speed,
    input  logic             run_en,
    input  logic             step_req,
    input  logic [15:0]      inst,
    output logic             cpu_clk,
    output logic             cpu_tick,
    output logic             force_boot,
    output logic [2:0]       state,
    output logic             halted,
    output logic             led,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned MATCH_W = $clog2(HALT_CONFIRM + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_STEP  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                cpu_clk_q, cpu_clk_d;
    logic                cpu_tick_q, cpu_tick_d;
    logic                force_boot_q, force_boot_d;
    logic                halted_q, halted_d;
    logic                led_q, led_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic [2:0]          step_sync_q, step_sync_d;

    logic [DIV_W-1:0]    div_last_s;
    logic                terminal_s;
    logic                step_evt_s;
    logic                halt_pend_s;
    logic                active_s;

    // Terminal count of the currently selected divider; speed changes apply at once.
    always_comb begin
        case (speed)
            2'd0:    div_last_s = DIV_W'(DIV0 - 1);
            2'd1:    div_last_s = DIV_W'(DIV1 - 1);
            2'd2:    div_last_s = DIV_W'(DIV2 - 1);
            2'd3:    div_last_s = DIV_W'(DIV3 - 1);
            default: div_last_s = DIV_W'(DIV3 - 1);
        endcase
    end

    // Counter at or beyond the new limit is treated as terminal this cycle.
    assign terminal_s = (div_cnt_q >= div_last_s);
    assign active_s   = (state_q == ST_RUN) || (state_q == ST_STEP);

    // Step button: bits [1:0] synchronise, bit [2] is the previous value for edge detect.
    assign step_sync_d = {step_sync_q[1:0], step_req};
    assign step_evt_s  = step_sync_q[1] & ~step_sync_q[2];

    // Halt-match tracking and cycle counting, both sampled on the tick cycle.
    always_comb begin
        match_cnt_d   = match_cnt_q;
        cycle_count_d = cycle_count_q;
        if (active_s && cpu_tick_q) begin
            if (inst == HALT_INST) begin
                if (match_cnt_q >= MATCH_W'(HALT_CONFIRM)) begin
                    match_cnt_d = MATCH_W'(HALT_CONFIRM);
                end else begin
                    match_cnt_d = match_cnt_q + MATCH_W'(1);
                end
            end else begin
                match_cnt_d = {MATCH_W{1'b0}};
            end
        end else begin
            match_cnt_d = match_cnt_q;
        end
        if (cpu_tick_q && (inst != HALT_INST)) begin
            cycle_count_d = sat_inc(cycle_count_q);
        end else begin
            cycle_count_d = cycle_count_q;
        end
    end

    // Includes a match landing this very cycle so fast dividers still halt on time.
    assign halt_pend_s = (match_cnt_d == MATCH_W'(HALT_CONFIRM));

    // Run-control FSM and clock divider: next state, divider count and cpu_clk edge.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        cpu_clk_d  = cpu_clk_q;
        cpu_tick_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                div_cnt_d = {DIV_W{1'b0}};
                cpu_clk_d = 1'b0;
                if (run_en) begin
                    state_d = ST_RUN;
                end else if (step_evt_s) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN, ST_STEP: begin
                if (!cpu_clk_q && halt_pend_s) begin
                    // Clock already low: nothing to finish, halt now.
                    state_d   = ST_HALT;
                    div_cnt_d = {DIV_W{1'b0}};
                end else if ((state_q == ST_RUN) && !cpu_clk_q && !run_en) begin
                    // Low phase: stop immediately, no runt high pulse.
                    state_d   = ST_PAUSE;
                    div_cnt_d = {DIV_W{1'b0}};
                end else if (terminal_s) begin
                    div_cnt_d = {DIV_W{1'b0}};
                    cpu_clk_d = ~cpu_clk_q;
                    if (!cpu_clk_q) begin
                        cpu_tick_d = 1'b1;
                        state_d    = state_q;
                    end else if (halt_pend_s) begin
                        state_d = ST_HALT;
                    end else if (state_q == ST_STEP) begin
                        state_d = run_en ? ST_RUN : ST_PAUSE;
                    end else if (!run_en) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_HALT: begin
                div_cnt_d = {DIV_W{1'b0}};
                cpu_clk_d = 1'b0;
                state_d   = ST_HALT;
            end
            default: begin
                div_cnt_d = {DIV_W{1'b0}};
                cpu_clk_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Status outputs derived from the next state so they register alongside it.
    always_comb begin
        force_boot_d = force_boot_q & (cpu_clk_d == cpu_clk_q);
        halted_d     = (state_d == ST_HALT);
        case (state_d)
            ST_RUN, ST_STEP: led_d = cpu_clk_d;
            ST_HALT:         led_d = 1'b1;
            default:         led_d = 1'b0;
        endcase
    end

    // State register for everything; init_n clears it asynchronously.
    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n) begin
            state_q       <= ST_IDLE;
            div_cnt_q     <= {DIV_W{1'b0}};
            cpu_clk_q     <= 1'b0;
            cpu_tick_q    <= 1'b0;
            force_boot_q  <= 1'b1;
            halted_q      <= 1'b0;
            led_q         <= 1'b0;
            cycle_count_q <= {CNT_W{1'b0}};
            match_cnt_q   <= {MATCH_W{1'b0}};
            step_sync_q   <= 3'b000;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            cpu_clk_q     <= cpu_clk_d;
            cpu_tick_q    <= cpu_tick_d;
            force_boot_q  <= force_boot_d;
            halted_q      <= halted_d;
            led_q         <= led_d;
            cycle_count_q <= cycle_count_d;
            match_cnt_q   <= match_cnt_d;
            step_sync_q   <= step_sync_d;
        end
    end

    assign cpu_clk     = cpu_clk_q;
    assign cpu_tick    = cpu_tick_q;
    assign force_boot  = force_boot_q;
    assign state       = state_q;
    assign halted      = halted_q;
    assign led         = led_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_xm23_run_control.sv
// Bench for xm23_run_control with scaled dividers and a 4-bit cycle counter:
// a vector table, hand sequences for halt/speed/saturation, and randomized
// traffic checked against a timestamp-based reference model.
module tb_xm23_run_control;

    localparam int D0 = 20;
    localparam int D1 = 1;
    localparam int D2 = 1200;
    localparam int D3 = 3;
    localparam int CW = 4;
    localparam int HC = 2;
    localparam logic [15:0] HALT = 16'h3FFF;

    logic          clk_in = 1'b0;
    logic          init_n;
    logic [1:0]    speed;
    logic          run_en;
    logic          step_req;
    logic [15:0]   inst;
    logic          cpu_clk, cpu_tick, force_boot, halted, led;
    logic [2:0]    state;
    logic [CW-1:0] cycle_count;

    int n_cmp = 0;
    int n_bad = 0;

    xm23_run_control #(
        .DIV_W(32), .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3),
        .CNT_W(CW), .HALT_INST(HALT), .HALT_CONFIRM(HC)
    ) dut (
        .clk_in(clk_in), .init_n(init_n), .speed(speed), .run_en(run_en),
        .step_req(step_req), .inst(inst), .cpu_clk(cpu_clk), .cpu_tick(cpu_tick),
        .force_boot(force_boot), .state(state), .halted(halted), .led(led),
        .cycle_count(cycle_count)
    );

    always #10 clk_in = ~clk_in;

    // ---------------- reference model (absolute-timestamp view) -------------
    int cyc_no = 0;
    int m_st, m_clk, m_tick, m_fb, m_cnt, m_match, m_at;
    bit r1, r2, r3;

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'd0:    return D0;
            2'd1:    return D1;
            2'd2:    return D2;
            default: return D3;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_clk = 0; m_tick = 0; m_fb = 1; m_cnt = 0; m_match = 0;
        m_at = 0; r1 = 0; r2 = 0; r3 = 0;
    endtask

    // One clk_in rising edge: step events are the 0->1 of step_req seen two edges late;
    // cpu_clk flips at scheduled timestamps DIV cycles apart.
    task automatic model_step();
        bit ev;
        bit hp;
        int d;
        cyc_no++;
        if (!init_n) begin
            model_reset();
            return;
        end
        d  = div_of(speed);
        ev = r2 && !r3;
        r3 = r2; r2 = r1; r1 = step_req;
        if (m_tick != 0) begin
            if (inst == HALT) m_match = (m_match < HC) ? m_match + 1 : HC;
            else begin
                m_match = 0;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
        end
        hp = (m_match == HC);
        m_tick = 0;
        if (m_st == 0 || m_st == 2) begin
            if (run_en) begin m_st = 1; m_at = cyc_no + d; end
            else if (ev) begin m_st = 3; m_at = cyc_no + d; end
        end else if (m_st == 1 || m_st == 3) begin
            if (m_clk == 0 && hp) m_st = 4;
            else if (m_st == 1 && m_clk == 0 && !run_en) m_st = 2;
            else if (cyc_no == m_at) begin
                m_at = cyc_no + d;
                m_fb = 0;
                if (m_clk == 0) begin
                    m_clk = 1; m_tick = 1;
                end else begin
                    m_clk = 0;
                    if (hp) m_st = 4;
                    else if (m_st == 3) m_st = run_en ? 1 : 2;
                    else if (!run_en) m_st = 2;
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_in);
            model_step();
            @(negedge clk_in);
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        init_n = 1'b0; run_en = 1'b0; step_req = 1'b0; inst = 16'h0000; speed = 2'd3;
        cyc(3);
        init_n = 1'b1;
    endtask

    typedef struct {
        bit run; bit stp; int n;
        int st; bit clk; bit tk; bit fb; bit ld; int cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int bad;
        logic [11:0] act_v, exp_v;
        int hold, p_halt;

        // run/pause/step from reset at speed 3 (half-period 3)
        tbl[0]  = '{0, 0,   2, 0, 0, 0, 1, 0,  0};
        tbl[1]  = '{1, 0,   1, 1, 0, 0, 1, 0,  0};
        tbl[2]  = '{1, 0,   3, 1, 1, 1, 0, 1,  0};
        tbl[3]  = '{1, 0,   1, 1, 1, 0, 0, 1,  1};
        tbl[4]  = '{1, 0,   2, 1, 0, 0, 0, 0,  1};
        tbl[5]  = '{1, 0,  52, 1, 1, 0, 0, 1, 10};
        tbl[6]  = '{0, 0,   1, 1, 1, 0, 0, 1, 10};
        tbl[7]  = '{0, 0,   1, 2, 0, 0, 0, 0, 10};
        tbl[8]  = '{0, 0, 100, 2, 0, 0, 0, 0, 10};
        tbl[9]  = '{1, 0,   3, 1, 0, 0, 0, 0, 10};
        tbl[10] = '{1, 0,   1, 1, 1, 1, 0, 1, 10};
        tbl[11] = '{0, 0,   1, 1, 1, 0, 0, 1, 11};
        tbl[12] = '{0, 0,   2, 2, 0, 0, 0, 0, 11};
        tbl[13] = '{0, 1,   4, 3, 0, 0, 0, 0, 11};
        tbl[14] = '{0, 0,   2, 3, 1, 1, 0, 1, 11};
        tbl[15] = '{0, 0,   3, 2, 0, 0, 0, 0, 12};

        model_reset();
        init_n = 1'b0; run_en = 1'b0; step_req = 1'b0; inst = 16'h0000; speed = 2'd3;
        cyc(3);
        chk("reset.state", state, 0);
        chk("reset.cpu_clk", cpu_clk, 0);
        chk("reset.force_boot", force_boot, 1);
        chk("reset.count", cycle_count, 0);
        chk("reset.led", led, 0);
        init_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_en = tbl[i].run; step_req = tbl[i].stp;
            cyc(tbl[i].n);
            chk($sformatf("vec%0d.state", i), state, tbl[i].st);
            chk($sformatf("vec%0d.cpu_clk", i), cpu_clk, tbl[i].clk);
            chk($sformatf("vec%0d.cpu_tick", i), cpu_tick, tbl[i].tk);
            chk($sformatf("vec%0d.force_boot", i), force_boot, tbl[i].fb);
            chk($sformatf("vec%0d.led", i), led, tbl[i].ld);
            chk($sformatf("vec%0d.count", i), cycle_count, tbl[i].cnt);
            chk($sformatf("vec%0d.halted", i), halted, 0);
        end

        // step pulse while running is ignored
        run_en = 1'b1;
        cyc(2);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            step_req = (k < 4);
            cyc(1);
            if (state != 3'd1) bad++;
        end
        chk("step_in_run.non_run_cycles", bad, 0);

        // confirmed halt on two ticks of the finish instruction
        do_reset();
        run_en = 1'b1; inst = HALT;
        cyc(12);
        chk("halt.pre_state", state, 1);
        chk("halt.pre_halted", halted, 0);
        cyc(1);
        chk("halt.state", state, 4);
        chk("halt.halted", halted, 1);
        chk("halt.led", led, 1);
        chk("halt.cpu_clk", cpu_clk, 0);
        chk("halt.count", cycle_count, 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            run_en = $urandom_range(0, 1);
            inst = 16'h0000;
            cyc(1);
            if (state != 3'd4 || cpu_clk != 1'b0 || led != 1'b1) bad++;
        end
        chk("halt.sticky", bad, 0);
        init_n = 1'b0;
        #1;
        chk("halt.async_reset_state", state, 0);
        chk("halt.async_reset_halted", halted, 0);
        cyc(1);
        init_n = 1'b1;

        // speed 2 -> 3 with counter at 1000, then 3 -> 0
        do_reset();
        speed = 2'd2; run_en = 1'b1;
        cyc(1001);
        chk("speed.pre_clk", cpu_clk, 0);
        speed = 2'd3;
        cyc(1);
        chk("speed.imm_toggle", cpu_clk, 1);
        chk("speed.imm_tick", cpu_tick, 1);
        cyc(2);
        chk("speed.high_hold", cpu_clk, 1);
        cyc(1);
        chk("speed.fall", cpu_clk, 0);
        speed = 2'd0;
        cyc(19);
        chk("speed.slow_low_hold", cpu_clk, 0);
        cyc(1);
        chk("speed.slow_rise", cpu_clk, 1);

        // divide-by-1 and counter saturation
        do_reset();
        speed = 2'd1; run_en = 1'b1;
        cyc(2);
        chk("div1.rise", cpu_clk, 1);
        cyc(1);
        chk("div1.fall", cpu_clk, 0);
        cyc(18);
        chk("sat.count10", cycle_count, 10);
        cyc(10);
        chk("sat.count15", cycle_count, 15);
        cyc(6);
        chk("sat.stuck", cycle_count, 15);

        // randomized traffic against the reference model
        for (int seg = 0; seg < 6; seg++) begin
            init_n = 1'b0; run_en = 1'b0; step_req = 1'b0; inst = 16'h0000;
            speed = (seg % 3 == 0) ? 2'd3 : ((seg % 3 == 1) ? 2'd1 : 2'd0);
            cyc(2);
            init_n = 1'b1;
            hold = 0;
            p_halt = (seg % 2 == 0) ? 10 : 2;
            for (int c = 0; c < 700; c++) begin
                if (hold == 0) begin
                    run_en = ($urandom_range(0, 2) == 0);
                    hold = $urandom_range(5, 60);
                end else begin
                    hold--;
                end
                if ($urandom_range(0, 7) == 0) step_req = ~step_req;
                if ($urandom_range(1, p_halt) == 1) inst = HALT;
                else begin
                    inst = 16'($urandom_range(0, 16'hFFFF));
                    if (inst == HALT) inst = 16'h0000;
                end
                cyc(1);
                act_v = {state, cpu_clk, cpu_tick, force_boot, halted, led, cycle_count};
                exp_v = {3'(m_st), m_clk[0], m_tick[0], m_fb[0], (m_st == 4), 
                         ((m_st == 1 || m_st == 3) ? m_clk[0] : (m_st == 4)), 4'(m_cnt)};
                chk($sformatf("rand.seg%0d.cyc%0d", seg, c), act_v, exp_v);
                if (act_v != exp_v) break;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xm23_run_control.md
Name: xm23_run_control

Overview:
- Parametrised successor to the XM23 top-level clock divider, cycle counter and PC-force logic, pulled out as a standalone controller.
- Generates the divided CPU clock (cpu_clk) and a matching one-cycle enable (cpu_tick) from the 50 MHz clk_in.
- Adds run/pause/single-step/halt control, confirmed halt detection on the finish instruction, and a saturating, width-parametrised cycle counter.
- Sits between the board switches/buttons and program_counter, p_ram address forcing, pipeline and seven-segment driver.

Parameters:
DIV_W, 32, width of divider counter
DIV0, 25000000, clk_in edges per cpu_clk half-period for speed=0 (1 Hz)
DIV1, 2500000, half-period for speed=1 (10 Hz)
DIV2, 250000, half-period for speed=2 (100 Hz)
DIV3, 3, half-period for speed=3 (8.333 MHz); all DIVn >= 1
CNT_W, 64, cycle_count width
HALT_INST, 16'h3FFF, finish instruction (BRA to self)
HALT_CONFIRM, 2, consecutive cpu_tick samples of HALT_INST required to halt (>= 1)

Ports:
clk_in  in  1  50 MHz clock, all state on rising edge
init_n  in  1  asynchronous active-low reset
speed  in  2  divider select
run_en  in  1  level: 1 = free run, 0 = pause
step_req  in  1  asynchronous step button, active high
inst  in  16  instruction currently at fetch (p_ram q)
cpu_clk  out  1  divided CPU clock, glitch-free
cpu_tick  out  1  one clk_in pulse coincident with each cpu_clk 0->1
force_boot  out  1  1 = force p_ram address to 7FFF
state  out  3  0 IDLE, 1 RUN, 2 PAUSE, 3 STEP, 4 HALT
halted  out  1  state == HALT
led  out  1  status LED
cycle_count  out  CNT_W  counted CPU cycles

Behaviour:
- Reset (init_n=0, async): state IDLE, divider counter 0, cpu_clk 0, cpu_tick 0, force_boot 1, halted 0, led 0, cycle_count 0, halt-match count 0, step synchroniser cleared.
- Divider: active only in RUN or STEP.
  - Counter counts 0..DIVsel-1. At DIVsel-1 it returns to 0 and toggles cpu_clk.
  - cpu_tick=1 in the clk_in cycle where cpu_clk goes 0->1 (registered together with the toggle).
  - Speed change takes effect immediately. If the counter is >= new DIVsel-1, treat it as terminal count this cycle (toggle and reset the counter).
  - DIVsel=1 toggles every clk_in.
- force_boot: cleared on the first cpu_clk toggle after reset; stays 0 until the next reset.
- step_req: 2-flop synchroniser plus rising-edge detect. A step event is a one-cycle pulse.
- FSM:
  - IDLE: run_en=1 -> RUN. Step event -> STEP.
  - RUN: run_en=0 -> stop at the next cpu_clk 1->0 toggle (or at once if cpu_clk=0), counter set to 0, go to PAUSE. No runt pulses. Step events ignored.
  - PAUSE: run_en=1 -> RUN. Step event -> STEP. cpu_clk held 0.
  - STEP: exactly one full period (one rising and one falling toggle, each after DIVsel cycles) -> PAUSE.
    - Step events during STEP are ignored.
    - If run_en rises during STEP, the period completes, then the FSM goes to RUN directly.
  - Halt detection (RUN or STEP only): on each cpu_tick, if inst==HALT_INST increment the match count (saturating at HALT_CONFIRM), else clear it.
    - When the count reaches HALT_CONFIRM, the FSM goes to HALT at the next cpu_clk 1->0 toggle.
    - Halt takes priority over run_en=0 and over a pending STEP return.
  - HALT: cpu_clk held 0. Exit only via reset.
- cycle_count: +1 on each cpu_tick where inst != HALT_INST. Saturates at all-ones and never wraps.
- led:
  - follows cpu_clk in RUN/STEP
  - 0 in IDLE/PAUSE
  - steady 1 in HALT
- Reset asserted mid-period: everything returns to reset values immediately. cpu_clk may be truncated; this is acceptable only under reset.

Test Plan:
- DIV3=3, speed=3, run_en=1 after reset: cpu_clk period is 6 clk_in cycles. First rising edge 3 cycles after RUN entry. force_boot falls with the first toggle. cycle_count=10 after 10 cpu_tick with inst=0.
- Run 5 ticks, then run_en=0 while cpu_clk=1: cpu_clk completes its high phase, then stays 0. state=PAUSE. cycle_count=5 and frozen for 100 clk_in.
- In PAUSE, pulse step_req for 4 clk_in, twice separated by 30 cycles: exactly 2 cpu_tick pulses, cycle_count +2, state returns to PAUSE each time. A step pulse in RUN gives no change.
- inst=16'h3FFF held, HALT_CONFIRM=2: halted=1 after the 2nd tick's falling phase. cycle_count unchanged by both ticks. led=1. run_en toggling has no effect. init_n=0 returns to IDLE with count 0.
- Speed switched from 2 to 3 with the counter at 1000: immediate toggle, then 3-cycle half-periods. Switching from 3 to 0: the next half-period lasts 25000000 cycles (scaled run: DIV0=20).
- CNT_W=4: after 15 ticks cycle_count=4'hF, and it stays 4'hF after 3 more ticks.
